rca_stage_ctrl: RTL and testbench
=================================

// Module: rca_stage_ctrl
//
// PURPOSE
// - Sequential staging controller wrapped around a combinational ripple-carry adder.
// - Sits upstream and downstream of the adder in the same block:
//   - takes operand pairs on a valid/ready input channel;
//   - registers the pair and drives it onto the adder inputs;
//   - holds the inputs stable for SETTLE_CYCLES, treating the ripple path as a multicycle path;
//   - captures the adder result and presents it on a valid/ready output channel.
// - The adder is external, so any adder architecture of matching width plugs in unchanged.
//
// PARAMETERS
// - WIDTH          23  operand width; the result is WIDTH+1 bits (carry-out is the MSB).
// - SETTLE_CYCLES   2  full cycles the operands are held stable before the result is captured. Must be >= 1.
// - CNT_W          16  width of the completed-transaction counter.
//
// PORTS
// - i_clk          in   1        clock, rising edge.
// - i_rst_n        in   1        asynchronous reset, active-low.
// - i_valid        in   1        operand pair valid.
// - o_ready        out  1        controller can accept an operand pair.
// - i_add_term1    in   WIDTH    operand A.
// - i_add_term2    in   WIDTH    operand B.
// - o_term1        out  WIDTH    registered operand A, drives adder input 1.
// - o_term2        out  WIDTH    registered operand B, drives adder input 2.
// - i_result       in   WIDTH+1  adder sum output, {carry, sum}.
// - o_valid        out  1        result valid.
// - i_ready        in   1        downstream accepts the result.
// - o_result       out  WIDTH+1  captured result.
// - o_txn_count    out  CNT_W    number of completed output handshakes; wraps.
//
// BEHAVIOUR
// - Reset: one clock, asynchronous active-low reset.
//   - Asserting i_rst_n=0 forces state IDLE immediately.
//   - o_term1, o_term2, o_result and o_txn_count reset to 0; o_valid resets to 0.
//   - o_ready = (state==IDLE), so it is 1 both during and after reset.
// - States: IDLE, SETTLE, OUT.
// - IDLE
//   - An accept occurs when i_valid && o_ready on edge N.
//   - On accept: o_term1/o_term2 <= i_add_term1/i_add_term2, settle counter <= SETTLE_CYCLES-1, go to SETTLE.
// - SETTLE
//   - The counter decrements once per cycle.
//   - At counter==0: o_result <= i_result and go to OUT.
//   - Capture happens on edge N+SETTLE_CYCLES, so the operands are stable for exactly SETTLE_CYCLES full cycles.
//   - i_valid is ignored (o_ready=0).
// - OUT
//   - o_valid=1, and o_result is held stable until the handshake.
//   - A handshake occurs on i_ready.
//   - On handshake: go to IDLE and o_txn_count <= o_txn_count+1, wrapping at 2^CNT_W-1 -> 0.
// - Throughput and latency
//   - No accept/emit overlap: at most one transaction is in flight.
//   - With i_ready held at 1, accepts are spaced SETTLE_CYCLES+2 edges apart.
//   - Latency from the accept edge to the first o_valid=1 cycle is SETTLE_CYCLES edges.
// - o_term1/o_term2 retain their last value in IDLE; they are not cleared after a transaction.
// - Widths
//   - i_result is captured verbatim, with no truncation or sign handling.
//   - The carry in o_result[WIDTH] comes from the adder, not from the controller.
// - Reset mid-operation: any in-flight transaction is dropped, o_valid falls at once and o_txn_count is cleared.
// - Backpressure: if i_ready stays 0, the controller stays in OUT indefinitely, with o_ready=0 and o_result stable.
// - The settle counter is sized clog2(SETTLE_CYCLES+1).
// - SETTLE_CYCLES < 1 is an elaboration error.
//
// STRUCTURE
// - Shared package rca_stage_pkg:
//   - state enum {IDLE, SETTLE, OUT};
//   - the default WIDTH/SETTLE_CYCLES constants.
// - Sub-module: none inside the controller. The adder (ripple-carry or another architecture) is instantiated alongside it at the next level up.
// - Single always_ff block for state, counter and registers; combinational o_ready/o_valid derived from state.
//
// TESTING
// - Bench instantiates the controller plus a 23-bit ripple-carry adder, with SETTLE_CYCLES=2.
// - T1 reset: hold i_rst_n=0, then release.
//   - Required: o_valid=0, o_ready=1, o_result=0, o_txn_count=0.
// - T2 basic add: A=0x7FFFFF, B=0x000001 accepted on edge N.
//   - Required: o_valid rises after edge N+2, o_result=0x0800000.
//   - After the i_ready handshake, o_txn_count=1.
// - T3 carry-out: A=B=0x7FFFFF.
//   - Required: o_result=0xFFFFFE (carry bit 23 = 1).
//   - A mutated i_result that changes after the capture edge must not alter o_result.
// - T4 backpressure: hold i_ready=0 for 10 cycles while driving i_valid=1 with new operands.
//   - Required: o_ready=0 throughout, o_result stable, the second pair accepted only after the handshake.
// - T5 reset mid-SETTLE: assert i_rst_n=0 one cycle after an accept.
//   - Required: immediate return to IDLE, o_valid never asserts, o_txn_count=0.
// - T6 wrap: run with CNT_W=4 for 17 transactions with i_ready=1.
//   - Required: o_txn_count wraps to 0 on the 16th transaction, reads 1 after the 17th, and accepts are spaced 4 edges apart.

Source files
------------

// File: rtl/rca_stage_pkg.sv
// Shared types and default constants for the ripple-carry staging controller.
// The state enum is the FSM encoding; the DEF_* values are the reference configuration.
package rca_stage_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    localparam int DEF_WIDTH         = 23;
    localparam int DEF_SETTLE_CYCLES = 2;
    localparam int DEF_CNT_W         = 16;

    // The settle counter only ever holds values 0..SETTLE_CYCLES-1.
    function automatic int settle_cnt_w(input int settle_cycles);
        return $clog2(settle_cycles + 1);
    endfunction

endpackage

// File: rtl/rca_adder.sv
// Combinational ripple-carry adder; the result is {carry_out, sum}.
// Instantiated next to rca_stage_ctrl, which treats its carry chain as a multicycle path.
module rca_adder #(
    parameter int WIDTH = 23
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum
);

    logic carry;

    // NOTE: blocking assignments in combinational logic, with every output given a default
    // at the top of the block so no path can leave a value unassigned and infer a latch.
    always_comb begin
        sum   = '0;
        carry = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        sum[WIDTH] = carry;
    end

endmodule

// File: rtl/rca_stage_ctrl.sv
// Staging controller around an external adder: accepts an operand pair, holds it stable on
// the adder inputs for SETTLE_CYCLES, captures the sum and hands it off on a valid/ready channel.
module rca_stage_ctrl
    import rca_stage_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    output logic [WIDTH-1:0] o_term1,
    output logic [WIDTH-1:0] o_term2,
    input  logic [WIDTH:0]   i_result,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic [CNT_W-1:0] o_txn_count
);

    localparam int SCW = settle_cnt_w(SETTLE_CYCLES);

    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("rca_stage_ctrl: SETTLE_CYCLES must be >= 1");
    end

    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(SETTLE_CYCLES - 1);

    state_t         state;
    logic [SCW-1:0] settle_cnt;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == OUT);

    // NOTE: all sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order inside the block.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            o_term1     <= '0;
            o_term2     <= '0;
            o_result    <= '0;
            o_txn_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        o_term1    <= i_add_term1;
                        o_term2    <= i_add_term2;
                        settle_cnt <= SETTLE_LOAD;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    // Capture lands on accept edge + SETTLE_CYCLES.
                    if (settle_cnt == '0) begin
                        o_result <= i_result;
                        state    <= OUT;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                OUT: begin
                    if (i_ready) begin
                        o_txn_count <= o_txn_count + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_stage_ctrl.sv
// Self-checking bench for rca_stage_ctrl paired with a 23-bit ripple-carry adder.
// Expected sums, latencies and handshake counts come from plain arithmetic on the driven operands.
module tb_rca_stage_ctrl;

    localparam int WIDTH   = 23;
    localparam int SETTLE  = 2;
    localparam int CNT_W   = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int SPACING = SETTLE + 2;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_add_term1;
    logic [WIDTH-1:0] i_add_term2;
    logic [WIDTH-1:0] o_term1;
    logic [WIDTH-1:0] o_term2;
    logic [WIDTH:0]   i_result;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH:0]   o_result;
    logic [CNT_W-1:0] o_txn_count;

    logic [WIDTH:0]   adder_sum;
    logic             mut_en;
    logic [WIDTH:0]   mut_val;

    int tests = 0;
    int fails = 0;
    int exp_count = 0;

    always #5 i_clk = ~i_clk;

    assign i_result = mut_en ? mut_val : adder_sum;

    rca_adder #(.WIDTH(WIDTH)) u_adder (
        .a   (o_term1),
        .b   (o_term2),
        .sum (adder_sum)
    );

    rca_stage_ctrl #(
        .WIDTH         (WIDTH),
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CNT_W)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_add_term1 (i_add_term1),
        .i_add_term2 (i_add_term2),
        .o_term1     (o_term1),
        .o_term2     (o_term2),
        .i_result    (i_result),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_txn_count (o_txn_count)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [WIDTH:0] ref_sum(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic accept_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic keep_valid);
        int wait_cnt = 0;
        while (o_ready !== 1'b1 && wait_cnt < 50) begin
            tick();
            wait_cnt++;
        end
        check("ready_before_accept", 64'(o_ready), 64'(1'b1));
        i_add_term1 = a;
        i_add_term2 = b;
        i_valid     = 1'b1;
        tick();
        i_valid = keep_valid;
        check("accept_term1", 64'(o_term1), 64'(a));
        check("accept_term2", 64'(o_term2), 64'(b));
        check("ready_low_after_accept", 64'(o_ready), 64'(1'b0));
    endtask

    task automatic await_result(input logic [WIDTH:0] expected);
        int lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 64'(lat), 64'(SETTLE));
        check("result", 64'(o_result), 64'(expected));
    endtask

    task automatic finish_txn();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        exp_count = (exp_count + 1) % CNT_MOD;
        check("txn_count", 64'(o_txn_count), 64'(exp_count));
        check("valid_low_after_hs", 64'(o_valid), 64'(1'b0));
        check("ready_high_after_hs", 64'(o_ready), 64'(1'b1));
    endtask

    task automatic apply_reset();
        #2 i_rst_n = 1'b0;
        #1;
        exp_count = 0;
        tick();
        #2 i_rst_n = 1'b1;
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] a, b, a2, b2;
        logic [WIDTH:0]   held;
        logic             pre_r, pre_v;
        logic [WIDTH:0]   q[$];
        int               edge_n, last_acc, hs;

        i_rst_n     = 1'b0;
        i_valid     = 1'b0;
        i_ready     = 1'b0;
        i_add_term1 = '0;
        i_add_term2 = '0;
        mut_en      = 1'b0;
        mut_val     = '0;

        // T1: reset state, during and after reset.
        #3;
        check("rst_ready_during", 64'(o_ready), 64'(1'b1));
        check("rst_valid_during", 64'(o_valid), 64'(1'b0));
        tick();
        tick();
        #2 i_rst_n = 1'b1;
        tick();
        check("rst_valid", 64'(o_valid), 64'(1'b0));
        check("rst_ready", 64'(o_ready), 64'(1'b1));
        check("rst_result", 64'(o_result), 64'(0));
        check("rst_count", 64'(o_txn_count), 64'(0));
        check("rst_term1", 64'(o_term1), 64'(0));

        // T2: basic add with carry into bit 23 of the sum.
        accept_pair(23'h7FFFFF, 23'h000001, 1'b0);
        await_result(24'h800000);
        finish_txn();
        check("terms_retained", 64'(o_term1), 64'(23'h7FFFFF));

        // T3: carry-out, then a mutated i_result after capture must not leak through.
        accept_pair(23'h7FFFFF, 23'h7FFFFF, 1'b0);
        await_result(24'hFFFFFE);
        mut_val = 24'h123456;
        mut_en  = 1'b1;
        tick();
        tick();
        check("result_held_vs_mutation", 64'(o_result), 64'(24'hFFFFFE));
        mut_en = 1'b0;
        finish_txn();

        // T4: backpressure with a second pair already offered.
        a  = 23'h155555;
        b  = 23'h0AAAAA;
        a2 = 23'h001234;
        b2 = 23'h004321;
        accept_pair(a, b, 1'b0);
        await_result(ref_sum(a, b));
        held        = o_result;
        i_add_term1 = a2;
        i_add_term2 = b2;
        i_valid     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_ready_low", 64'(o_ready), 64'(1'b0));
            check("bp_valid_high", 64'(o_valid), 64'(1'b1));
            check("bp_result_stable", 64'(o_result), 64'(held));
        end
        finish_txn();
        check("bp_no_early_accept", 64'(o_term1), 64'(a));
        tick();
        i_valid = 1'b0;
        check("bp_second_accept_t1", 64'(o_term1), 64'(a2));
        check("bp_second_accept_t2", 64'(o_term2), 64'(b2));
        await_result(ref_sum(a2, b2));
        finish_txn();

        // Randomised transactions with random backpressure and idle gaps.
        for (int n = 0; n < 20; n++) begin
            a = WIDTH'($urandom());
            b = WIDTH'($urandom());
            if (n == 0) begin
                a = '0;
                b = '0;
            end
            accept_pair(a, b, 1'($urandom_range(0, 1)));
            await_result(ref_sum(a, b));
            held = o_result;
            for (int s = $urandom_range(0, 3); s > 0; s--) begin
                tick();
                check("rand_hold", 64'(o_result), 64'(held));
            end
            finish_txn();
            i_valid = 1'b0;
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        // T5: reset one cycle after an accept drops the transaction.
        check("pre_t5_count_nonzero", 64'(o_txn_count != '0), 64'(1'b1));
        accept_pair(23'h0F0F0F, 23'h00FF00, 1'b0);
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        exp_count = 0;
        check("midrst_ready", 64'(o_ready), 64'(1'b1));
        check("midrst_valid", 64'(o_valid), 64'(1'b0));
        check("midrst_count", 64'(o_txn_count), 64'(exp_count));
        check("midrst_term1", 64'(o_term1), 64'(0));
        tick();
        #2 i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst_never_valid", 64'(o_valid), 64'(1'b0));
        end

        // T6: streaming with i_ready=1 for 17 transactions; counter wraps at 16.
        apply_reset();
        i_ready     = 1'b1;
        i_valid     = 1'b1;
        i_add_term1 = WIDTH'($urandom());
        i_add_term2 = WIDTH'($urandom());
        edge_n   = 0;
        last_acc = -1;
        hs       = 0;
        while (hs < 17 && edge_n < 300) begin
            pre_r = o_ready;
            pre_v = o_valid;
            tick();
            edge_n++;
            if (pre_r) begin
                if (last_acc >= 0) check("accept_spacing", 64'(edge_n - last_acc), 64'(SPACING));
                last_acc = edge_n;
                q.push_back(ref_sum(i_add_term1, i_add_term2));
                i_add_term1 = WIDTH'($urandom());
                i_add_term2 = WIDTH'($urandom());
            end
            if (pre_v) begin
                hs++;
                exp_count = (exp_count + 1) % CNT_MOD;
                check("stream_count", 64'(o_txn_count), 64'(exp_count));
                if (hs == 16) check("wrap_to_zero", 64'(o_txn_count), 64'(0));
                if (q.size() > 0) void'(q.pop_front());
            end
            if (o_valid === 1'b1) begin
                if (q.size() > 0) check("stream_result", 64'(o_result), 64'(q[0]));
                else check("stream_unexpected_valid", 64'(o_valid), 64'(1'b0));
            end
        end
        check("stream_handshakes", 64'(hs), 64'(17));
        check("count_after_17", 64'(o_txn_count), 64'(1));
        i_valid = 1'b0;
        i_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
